product_accumulator: RTL and testbench
======================================

// Module: product_accumulator
// PURPOSE
//   Sequential stage directly downstream of the 3x3 gate-level multiplier.
//   Accepts its 6-bit products over a valid/ready handshake and sums a group
//   of up to NTERMS products (a dot-product / MAC back end).
//   Presents each group result on a registered output held until consumed.
//   Accumulator saturates on overflow and reports it with a flag.
// PARAMETERS
//   PROD_W  6   width of the incoming product (multiplier y output)
//   ACC_W   10  accumulator / result width; must be >= PROD_W
//   NTERMS  4   products per group before auto-close; must be >= 1
//   CW      $clog2(NTERMS+1)  derived localparam, width of out_count
// PORTS
//   clk        in   1       single clock, rising edge
//   rst_n      in   1       asynchronous, active-low reset
//   in_valid   in   1       in_prod/in_last valid this cycle
//   in_ready   out  1       stage can accept a product
//   in_prod    in   PROD_W  product from multiplier, unsigned
//   in_last    in   1       close the group early after this beat
//   out_valid  out  1       result group valid
//   out_ready  in   1       consumer accepts result
//   out_sum    out  ACC_W   group sum, unsigned, saturated
//   out_count  out  CW      number of products in the group (1..NTERMS)
//   out_ovf    out  1       saturation occurred within the group
// BEHAVIOUR
//   Reset (async, any time incl. mid-group): state=ACCUM, acc=0, cnt=0,
//     ovf=0, out_valid=0, out_sum=0, out_count=0, out_ovf=0, so in_ready=1.
//     A partial group in flight is discarded.
//   FSM: ACCUM, HOLD. in_ready = (state==ACCUM), decoded from registered state.
//   Beat = in_valid & in_ready. in_prod/in_last are ignored otherwise.
//   ACCUM, on a beat:
//     - sum = {1'b0,acc} + in_prod (ACC_W+1 bits).
//     - If sum[ACC_W]=1: acc_n = all ones, ovf_n = 1.
//       Else acc_n = sum[ACC_W-1:0], ovf_n = ovf.
//     - cnt_n = cnt+1.
//     - If cnt_n==NTERMS or in_last: next edge loads out_sum=acc_n,
//       out_count=cnt_n, out_ovf=ovf_n, out_valid=1. It also clears acc, cnt
//       and ovf and moves state to HOLD.
//     - Else acc/cnt/ovf update and state stays ACCUM.
//   ACCUM, no beat: all registers hold; bubbles are legal at any point.
//   HOLD: in_ready=0; out_sum/out_count/out_ovf stable while out_valid=1.
//     On out_valid & out_ready: out_valid=0 and state=ACCUM at the next edge.
//     in_ready is therefore 0 in the handshake cycle and 1 in the next.
//   Latency: out_valid rises the cycle after the closing beat.
//   Throughput: max one group per (group length + 1) cycles.
//   Once saturated, acc stays at all ones for the rest of the group.
//   out_ovf is per group, never sticky across groups.
//   NTERMS=1: every beat closes a group.
//   in_last on the NTERMS-th beat is the same as an auto-close.
//   out_valid is never deasserted without out_ready.
// TESTING
//   1 NTERMS=4, beats 49,49,49,49 back-to-back, out_ready=1 ->
//     out_sum=196, out_count=4, out_ovf=0, out_valid 1 cycle after beat 4.
//   2 Beats 10 then 5 with in_last=1 on the second -> out_sum=15,
//     out_count=2; next group starts from 0.
//   3 Group closes with out_ready=0 held 5 cycles -> out_valid=1, in_ready=0,
//     outputs stable; raise out_ready -> out_valid=0 and in_ready=1 next cycle.
//   4 ACC_W=6, beats 40,40,3 with in_last on beat 3 -> out_sum=63, out_ovf=1;
//     next group of 1,2 (in_last) -> out_sum=3, out_ovf=0.
//   5 Beats 7,8, then rst_n pulsed low mid-cycle -> all outputs 0 immediately,
//     in_ready=1; beats 1,1,1,1 -> out_sum=4, out_count=4.
//   6 Beats 4,4,4,4 with random in_valid bubbles -> out_sum=16, out_count=4.

Source files
------------

// File: rtl/product_accumulator.sv
// Product accumulator: sums groups of up to NTERMS unsigned multiplier products
// with saturation, presenting each group result on a registered, held output.
module product_accumulator #(
    parameter int unsigned PROD_W = 6,
    parameter int unsigned ACC_W  = 10,
    parameter int unsigned NTERMS = 4,
    localparam int unsigned CW    = $clog2(NTERMS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CW-1:0]     out_count,
    output logic              out_ovf
);

    typedef enum logic {
        S_ACCUM = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [CW-1:0]      r_cnt;
    logic               r_ovf;
    logic               r_out_valid;
    logic [ACC_W-1:0]   r_out_sum;
    logic [CW-1:0]      r_out_count;
    logic               r_out_ovf;

    state_t             w_state_n;
    logic [ACC_W-1:0]   w_acc_n;
    logic [CW-1:0]      w_cnt_n;
    logic               w_ovf_n;
    logic               w_out_valid_n;
    logic [ACC_W-1:0]   w_out_sum_n;
    logic [CW-1:0]      w_out_count_n;
    logic               w_out_ovf_n;

    logic               w_beat;
    logic [ACC_W:0]     w_sum;
    logic               w_sat;
    logic [ACC_W-1:0]   w_acc_upd;
    logic               w_ovf_upd;
    logic [CW-1:0]      w_cnt_inc;
    logic               w_close;

    // Datapath for one accepted beat; the extra sum bit is the overflow detector.
    assign w_beat    = in_valid & (r_state == S_ACCUM);
    assign w_sum     = {1'b0, r_acc} + (ACC_W + 1)'(in_prod);
    assign w_sat     = w_sum[ACC_W];
    assign w_acc_upd = w_sat ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
    assign w_ovf_upd = w_sat | r_ovf;
    assign w_cnt_inc = r_cnt + CW'(1);
    assign w_close   = (w_cnt_inc == CW'(NTERMS)) | in_last;

    // Next-state and register-update logic.
    always_comb begin
        w_state_n     = r_state;
        w_acc_n       = r_acc;
        w_cnt_n       = r_cnt;
        w_ovf_n       = r_ovf;
        w_out_valid_n = r_out_valid;
        w_out_sum_n   = r_out_sum;
        w_out_count_n = r_out_count;
        w_out_ovf_n   = r_out_ovf;
        case (r_state)
            S_ACCUM: begin
                if (w_beat) begin
                    if (w_close) begin
                        w_out_valid_n = 1'b1;
                        w_out_sum_n   = w_acc_upd;
                        w_out_count_n = w_cnt_inc;
                        w_out_ovf_n   = w_ovf_upd;
                        w_acc_n       = '0;
                        w_cnt_n       = '0;
                        w_ovf_n       = 1'b0;
                        w_state_n     = S_HOLD;
                    end else begin
                        w_acc_n = w_acc_upd;
                        w_cnt_n = w_cnt_inc;
                        w_ovf_n = w_ovf_upd;
                    end
                end
            end
            S_HOLD: begin
                if (r_out_valid & out_ready) begin
                    w_out_valid_n = 1'b0;
                    w_state_n     = S_ACCUM;
                end
            end
            default: begin
                w_state_n = S_ACCUM;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial group.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_ACCUM;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_count <= '0;
            r_out_ovf   <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_acc       <= w_acc_n;
            r_cnt       <= w_cnt_n;
            r_ovf       <= w_ovf_n;
            r_out_valid <= w_out_valid_n;
            r_out_sum   <= w_out_sum_n;
            r_out_count <= w_out_count_n;
            r_out_ovf   <= w_out_ovf_n;
        end
    end

    assign in_ready  = (r_state == S_ACCUM);
    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_count = r_out_count;
    assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: three configurations checked every cycle
// against a group-level arithmetic model, plus directed scenario checks.
module tb_product_accumulator;

    localparam int unsigned NI = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       iv[NI];
    logic       il[NI];
    logic       ordy[NI];
    logic [5:0] ip[NI];

    logic        ov[NI];
    logic        ir[NI];
    logic        oovf[NI];
    logic [31:0] osum[NI];
    logic [31:0] ocnt[NI];

    logic [9:0] s0;
    logic [5:0] s1;
    logic [9:0] s2;
    logic [2:0] c0;
    logic [2:0] c1;
    logic [0:0] c2;

    // u0: defaults; u1: narrow accumulator; u2: single-term groups
    product_accumulator #(.PROD_W(6), .ACC_W(10), .NTERMS(4)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_prod(ip[0]), .in_last(il[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
        .out_sum(s0), .out_count(c0), .out_ovf(oovf[0]));

    product_accumulator #(.PROD_W(6), .ACC_W(6), .NTERMS(4)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_prod(ip[1]), .in_last(il[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
        .out_sum(s1), .out_count(c1), .out_ovf(oovf[1]));

    product_accumulator #(.PROD_W(6), .ACC_W(10), .NTERMS(1)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_prod(ip[2]), .in_last(il[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
        .out_sum(s2), .out_count(c2), .out_ovf(oovf[2]));

    assign osum[0] = 32'(s0);
    assign osum[1] = 32'(s1);
    assign osum[2] = 32'(s2);
    assign ocnt[0] = 32'(c0);
    assign ocnt[1] = 32'(c1);
    assign ocnt[2] = 32'(c2);

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned nterms(input int k);
        return (k == 2) ? 1 : 4;
    endfunction

    function automatic int unsigned acc_max(input int k);
        return (k == 1) ? 63 : 1023;
    endfunction

    // Reference model: a group is a running integer total; saturation is min(total, max).
    bit          hold[NI];
    int unsigned gsum[NI];
    int unsigned gn[NI];
    int unsigned esum[NI];
    int unsigned ecnt[NI];
    bit          eovf[NI];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NI; k++) begin
                hold[k] = 0; gsum[k] = 0; gn[k] = 0;
                esum[k] = 0; ecnt[k] = 0; eovf[k] = 0;
            end
        end else begin
            for (int k = 0; k < NI; k++) begin
                if (!hold[k]) begin
                    if (iv[k]) begin
                        int unsigned total;
                        int unsigned n;
                        total = gsum[k] + int'(ip[k]);
                        n     = gn[k] + 1;
                        if (n == nterms(k) || il[k]) begin
                            hold[k] = 1;
                            esum[k] = (total > acc_max(k)) ? acc_max(k) : total;
                            eovf[k] = (total > acc_max(k));
                            ecnt[k] = n;
                            gsum[k] = 0;
                            gn[k]   = 0;
                        end else begin
                            gsum[k] = total;
                            gn[k]   = n;
                        end
                    end
                end else if (ordy[k]) begin
                    hold[k] = 0;
                end
            end
        end
    end

    // Cycle-by-cycle comparison of every instance against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < NI; k++) begin
                chk($sformatf("u%0d_in_ready", k), 32'(ir[k]), 32'(!hold[k]));
                chk($sformatf("u%0d_out_valid", k), 32'(ov[k]), 32'(hold[k]));
                if (hold[k]) begin
                    chk($sformatf("u%0d_out_sum", k), osum[k], esum[k]);
                    chk($sformatf("u%0d_out_count", k), ocnt[k], ecnt[k]);
                    chk($sformatf("u%0d_out_ovf", k), 32'(oovf[k]), 32'(eovf[k]));
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int k, input int p, input bit l);
        int n = 0;
        while (hold[k] && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (hold[k]) chk($sformatf("u%0d_send_timeout", k), 32'(hold[k]), 32'(0));
        iv[k] = 1'b1;
        ip[k] = 6'(p);
        il[k] = l;
        @(posedge clk);
        #1;
        iv[k] = 1'b0;
        il[k] = 1'b0;
    endtask

    task automatic chk_res(input string tag, input int k, input int s, input int c, input int o);
        chk({tag, "_valid"}, 32'(ov[k]), 32'(1));
        chk({tag, "_sum"}, osum[k], 32'(s));
        chk({tag, "_count"}, ocnt[k], 32'(c));
        chk({tag, "_ovf"}, 32'(oovf[k]), 32'(o));
    endtask

    task automatic chk_reset(input string tag);
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("%s_u%0d_valid", tag, k), 32'(ov[k]), 32'(0));
            chk($sformatf("%s_u%0d_sum", tag, k), osum[k], 32'(0));
            chk($sformatf("%s_u%0d_count", tag, k), ocnt[k], 32'(0));
            chk($sformatf("%s_u%0d_ovf", tag, k), 32'(oovf[k]), 32'(0));
            chk($sformatf("%s_u%0d_ready", tag, k), 32'(ir[k]), 32'(1));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < NI; k++) begin
            iv[k] = 1'b0; il[k] = 1'b0; ordy[k] = 1'b1; ip[k] = '0;
        end
        #12;
        chk_reset("por");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Four 49s back-to-back close automatically
        for (int i = 0; i < 4; i++) send(0, 49, 1'b0);
        chk_res("t1", 0, 196, 4, 0);
        idle(1);
        chk("t1_drop", 32'(ov[0]), 32'(0));

        // Early close with in_last, then a fresh group
        send(0, 10, 1'b0);
        send(0, 5, 1'b1);
        chk_res("t2", 0, 15, 2, 0);
        idle(1);
        send(0, 3, 1'b1);
        chk_res("t2b", 0, 3, 1, 0);
        idle(1);

        // Back-pressure: result held while out_ready is low
        ordy[0] = 1'b0;
        send(0, 1, 1'b0);
        send(0, 2, 1'b1);
        repeat (5) begin
            @(posedge clk);
            #1;
            chk_res("t3_hold", 0, 3, 2, 0);
            chk("t3_busy", 32'(ir[0]), 32'(0));
        end
        ordy[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("t3_valid_drop", 32'(ov[0]), 32'(0));
        chk("t3_ready_back", 32'(ir[0]), 32'(1));

        // Saturation on the 6-bit accumulator, not sticky across groups
        send(1, 40, 1'b0);
        send(1, 40, 1'b0);
        send(1, 3, 1'b1);
        chk_res("t4", 1, 63, 3, 1);
        idle(1);
        send(1, 1, 1'b0);
        send(1, 2, 1'b1);
        chk_res("t4b", 1, 3, 2, 0);
        idle(1);
        send(1, 60, 1'b0);
        send(1, 3, 1'b1);
        chk_res("t4_exact_max", 1, 63, 2, 0);
        idle(1);

        // Mid-group asynchronous reset discards partial work
        send(0, 7, 1'b0);
        send(0, 8, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset("t5");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) send(0, 1, 1'b0);
        chk_res("t5b", 0, 4, 4, 0);
        idle(1);

        // Bubbles between beats
        for (int i = 0; i < 4; i++) begin
            idle($urandom_range(0, 3));
            send(0, 4, 1'b0);
        end
        chk_res("t6", 0, 16, 4, 0);
        idle(1);

        // in_last on the final beat behaves like auto-close
        for (int i = 0; i < 4; i++) send(0, 2, (i == 3));
        chk_res("last_on_n", 0, 8, 4, 0);
        idle(1);

        // Single-term groups
        send(2, 63, 1'b0);
        chk_res("nt1", 2, 63, 1, 0);
        idle(1);

        // Random traffic on all instances with random back-pressure
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < NI; k++) begin
                iv[k]   = ($urandom_range(0, 3) != 0);
                ip[k]   = 6'($urandom);
                il[k]   = ($urandom_range(0, 3) == 0);
                ordy[k] = ($urandom_range(0, 2) != 0);
            end
            @(posedge clk);
            #1;
        end
        for (int k = 0; k < NI; k++) begin
            iv[k] = 1'b0; il[k] = 1'b0; ordy[k] = 1'b1;
        end
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
